// File: rtl/layer_stream_sequencer.sv
// Feeds one fully connected layer: latches an input vector, bursts it word by word onto the
// shared neuron input bus, gathers each neuron's result and hands the vector downstream.
module layer_stream_sequencer #(
    parameter int NUM_INPUTS  = 30,
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16,
    parameter int TIMEOUT     = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]  in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [DATA_WIDTH-1:0]             nrn_data,
    output logic                              nrn_valid,
    input  logic [NUM_NEURONS-1:0]            nrn_outvalid,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] nrn_out,
    output logic [NUM_NEURONS*DATA_WIDTH-1:0] out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              busy,
    output logic                              err
);
    localparam int CW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_HOLD} state_t;

    state_t                          state, state_nxt;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] vec_buf;
    logic [CW-1:0]                   cnt;
    logic [TW-1:0]                   timer;
    logic [NUM_NEURONS-1:0]          done;
    logic                            done_all;
    logic                            timeout;

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_HOLD);

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Bits captured this cycle count toward completion so HOLD follows the last pulse directly.
    always_comb begin
        state_nxt = state;
        done_all  = &(done | nrn_outvalid);
        timeout   = 1'b0;
        case (state)
            S_IDLE:   if (in_valid) state_nxt = S_STREAM;
            S_STREAM: if (cnt == CW'(NUM_INPUTS - 1)) state_nxt = S_WAIT;
            S_WAIT: begin
                if (done_all) begin
                    state_nxt = S_HOLD;
                end else if (timer + TW'(1) == TW'(TIMEOUT)) begin
                    timeout   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_HOLD:   if (out_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            timer     <= '0;
            done      <= '0;
            nrn_valid <= 1'b0;
            nrn_data  <= '0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            nrn_valid <= 1'b0;
            if ((state != S_WAIT && |nrn_outvalid) || timeout) err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        vec_buf <= in_data;
                        done    <= '0;
                        cnt     <= '0;
                        timer   <= '0;
                    end
                end
                S_STREAM: begin
                    nrn_data  <= vec_buf[int'(cnt)*DATA_WIDTH +: DATA_WIDTH];
                    nrn_valid <= 1'b1;
                    cnt       <= cnt + CW'(1);
                end
                S_WAIT: begin
                    timer <= timer + TW'(1);
                    // First pulse wins; repeats from a finished neuron are dropped.
                    for (int i = 0; i < NUM_NEURONS; i++) begin
                        if (nrn_outvalid[i] && !done[i]) begin
                            out_data[i*DATA_WIDTH +: DATA_WIDTH] <= nrn_out[i*DATA_WIDTH +: DATA_WIDTH];
                            done[i] <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_stream_sequencer.sv
// Directed bench for layer_stream_sequencer: burst, collection, backpressure, timeout,
// mid-burst reset and duplicate/stray neuron pulses.
module tb_layer_stream_sequencer;
    localparam int NI = 30;
    localparam int NN = 30;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NI*DW-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    nrn_data;
    logic             nrn_valid;
    logic [NN-1:0]    nrn_outvalid;
    logic [NN*DW-1:0] nrn_out;
    logic [NN*DW-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             err;

    int total = 0;
    int bad   = 0;

    layer_stream_sequencer #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_WIDTH(DW), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .nrn_data(nrn_data), .nrn_valid(nrn_valid), .nrn_outvalid(nrn_outvalid),
        .nrn_out(nrn_out), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] oword(input int i);
        return 32'(out_data[i*DW +: DW]);
    endfunction

    // Vector word k = base + k + 1; checks the 1-cycle handshake.
    task automatic send_vec(input int base);
        for (int k = 0; k < NI; k++) in_data[k*DW +: DW] = 16'(base + k + 1);
        chk("acc_rdy_before", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("acc_rdy_after", 32'(in_ready), 32'd0);
        chk("acc_nv_lat", 32'(nrn_valid), 32'd0);
    endtask

    task automatic burst(input int base);
        for (int k = 0; k < NI; k++) begin
            tick();
            chk("burst_vld", 32'(nrn_valid), 32'd1);
            chk("burst_dat", 32'(nrn_data), 32'(base + k + 1));
        end
    endtask

    // Neuron i pulses 5 + (i % 8) WAIT edges after the burst with value base + i.
    // dup: neuron 3 reports 0x0AAA, then repeats with 0x0BBB one cycle later.
    task automatic neurons(input int base, input int skip, input bit dup);
        for (int d = 1; d <= 12; d++) begin
            nrn_outvalid = '0;
            for (int i = 0; i < NN; i++) begin
                nrn_out[i*DW +: DW] = 16'(base + i);
                if (dup && i == 3) nrn_out[i*DW +: DW] = (d == 9) ? 16'h0BBB : 16'h0AAA;
                if (i != skip && 5 + (i % 8) == d) nrn_outvalid[i] = 1'b1;
                if (dup && i == 3 && d == 9) nrn_outvalid[i] = 1'b1;
            end
            tick();
            nrn_outvalid = '0;
            if (d == 1) chk("wait_nv_low", 32'(nrn_valid), 32'd0);
            if (d == 11) chk("ov_early", 32'(out_valid), 32'd0);
            if (d == 12) chk("ov_last", 32'(out_valid), (skip < 0) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic check_out(input int base, input bit dup);
        for (int i = 0; i < NN; i++)
            chk("out_word", oword(i), (dup && i == 3) ? 32'h0AAA : 32'(base + i));
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("acc_ov_low", 32'(out_valid), 32'd0);
        chk("acc_idle", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_ov;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; nrn_outvalid = '0; nrn_out = '0;
        tick(); tick();
        chk("rst_nv", 32'(nrn_valid), 32'd0);
        chk("rst_nd", 32'(nrn_data), 32'd0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_od", 32'(|out_data), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        rst = 1'b1;
        tick();

        // 1/2: words 1..30, neurons 0x0100+i
        send_vec(0);
        chk("t1_busy", 32'(busy), 32'd1);
        burst(0);
        neurons(16'h0100, -1, 1'b0);
        check_out(16'h0100, 1'b0);
        chk("t2_err", 32'(err), 32'd0);

        // 3: backpressure with a new vector already offered
        for (int k = 0; k < NI; k++) in_data[k*DW +: DW] = 16'(16'h0040 + k + 1);
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("t3_ov", 32'(out_valid), 32'd1);
            chk("t3_rdy", 32'(in_ready), 32'd0);
            chk("t3_w0", oword(0), 32'h0100);
            chk("t3_w29", oword(29), 32'h011D);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_acc_ov", 32'(out_valid), 32'd0);
        chk("t3_acc_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("t3_next_acc", 32'(in_ready), 32'd0);
        burst(16'h0040);
        neurons(16'h0300, -1, 1'b0);
        check_out(16'h0300, 1'b0);
        accept();

        // 4: neuron 7 silent -> abort after 64 WAIT cycles
        send_vec(16'h0080);
        burst(16'h0080);
        neurons(16'h0400, 7, 1'b0);
        seen_ov = out_valid;
        for (int j = 13; j <= 64; j++) begin
            tick();
            seen_ov |= out_valid;
            if (j == 63) begin
                chk("t4_busy63", 32'(busy), 32'd1);
                chk("t4_err63", 32'(err), 32'd0);
            end
        end
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_idle", 32'(in_ready), 32'd1);
        chk("t4_never_ov", 32'(seen_ov), 32'd0);
        chk("t4_w0", oword(0), 32'h0400);
        chk("t4_w7_kept", oword(7), 32'h0307);
        send_vec(16'h00C0);
        burst(16'h00C0);
        neurons(16'h0500, -1, 1'b0);
        check_out(16'h0500, 1'b0);
        chk("t4_err_sticky", 32'(err), 32'd1);
        accept();

        // 5: reset at the 12th burst word
        send_vec(0);
        for (int k = 0; k < 12; k++) tick();
        chk("t5_w12", 32'(nrn_data), 32'd12);
        rst = 1'b0;
        tick();
        chk("t5_nv", 32'(nrn_valid), 32'd0);
        chk("t5_nd", 32'(nrn_data), 32'd0);
        chk("t5_od", 32'(|out_data), 32'd0);
        chk("t5_ov", 32'(out_valid), 32'd0);
        chk("t5_err", 32'(err), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        tick();

        // 6: duplicate pulse keeps first value; stray pulse in IDLE flags error
        send_vec(16'h0010);
        burst(16'h0010);
        neurons(16'h0600, -1, 1'b1);
        check_out(16'h0600, 1'b1);
        chk("t6_err_dup", 32'(err), 32'd0);
        accept();
        nrn_outvalid = 30'h20;
        nrn_out[5*DW +: DW] = 16'h0DEF;
        tick();
        nrn_outvalid = '0;
        chk("t6_err_stray", 32'(err), 32'd1);
        chk("t6_w3", oword(3), 32'h0AAA);
        chk("t6_w5", oword(5), 32'h0605);
        chk("t6_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
